// File: rtl/conv_enc_pkg.sv
// conv_enc_pkg: shared state type, default generators and parity helper
// for the rate-1/2 convolutional encoder/packer.
package conv_enc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ENCODE,
      FLUSH,
      OUT
   } state_e;

   localparam logic [2:0] G0_DEF = 3'b111;
   localparam logic [2:0] G1_DEF = 3'b101;

   function automatic logic conv_parity(input logic [31:0] window,
                                        input logic [31:0] poly);
      return ^(window & poly);
   endfunction

endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: one-bit encoder step; holds the K-1 bit memory and
// produces the two parity bits for the current input bit.
module conv_enc_core
   import conv_enc_pkg::*;
#(
   parameter int             K  = 3,
   parameter logic [K-1:0]   G0 = K'(G0_DEF),
   parameter logic [K-1:0]   G1 = K'(G1_DEF)
) (
   input  logic clk,
   input  logic clr_i,
   input  logic en_i,
   input  logic b_i,
   output logic p0_o,
   output logic p1_o
);

   logic [K-2:0] s_q;
   logic [K-2:0] s_d;
   logic [K-1:0] w;

   assign w    = {b_i, s_q};
   assign s_d  = w[K-1:1];
   assign p0_o = conv_parity(32'(w), 32'(G0));
   assign p1_o = conv_parity(32'(w), 32'(G1));

   always_ff @(posedge clk) begin
      if (clr_i) begin
         s_q <= '0;
      end else if (en_i) begin
         s_q <= s_d;
      end
   end

endmodule

// File: rtl/conv_encoder_packer.sv
// conv_encoder_packer: serial rate-1/2 encoder with packet packing and
// zero-tail flush. Optional error injection under CONV_ENC_ERR_INJ_EN.
module conv_encoder_packer
   import conv_enc_pkg::*;
#(
   parameter int             DATA_W = 8,
   parameter int             K      = 3,
   parameter logic [K-1:0]   G0     = K'(G0_DEF),
   parameter logic [K-1:0]   G1     = K'(G1_DEF)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dvalid_i,
   input  logic [DATA_W-1:0]     data_i,
   input  logic                  flush_i,
   input  logic                  ready_i,
   output logic [2*DATA_W-1:0]   data_o,
   output logic                  valid_o,
   output logic                  last_o,
   output logic                  busy_o
`ifdef CONV_ENC_ERR_INJ_EN
   ,
   input  logic [2*DATA_W-1:0]   err_mask_i
`endif
);

   localparam int PW      = 2 * DATA_W;
   localparam int CW      = $clog2(DATA_W + 1);
   localparam int TAIL_SH = PW - 2 * (K - 1);

   state_e            state_q;
   logic [DATA_W-1:0] word_q;
   logic [CW-1:0]     cnt_q;
   logic [PW-1:0]     pkt_q;
   logic [PW-1:0]     data_q;
   logic              valid_q;
   logic              last_q;
   logic              busy_q;

   logic              step;
   logic              bit_in;
   logic              p0;
   logic              p1;
   logic [PW-1:0]     err_w;

`ifdef CONV_ENC_ERR_INJ_EN
   assign err_w = err_mask_i;
`else
   assign err_w = '0;
`endif

   assign step   = (state_q == ENCODE) || (state_q == FLUSH);
   assign bit_in = (state_q == ENCODE) ? word_q[0] : 1'b0;

   conv_enc_core #(
      .K  (K),
      .G0 (G0),
      .G1 (G1)
   ) u_core (
      .clk   (clk),
      .clr_i (!rst_n),
      .en_i  (step),
      .b_i   (bit_in),
      .p0_o  (p0),
      .p1_o  (p1)
   );

   // Pairs shift in at the bottom; tail packets are realigned to the MSBs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
         pkt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         busy_q <= (state_q != IDLE);
         unique case (state_q)
            IDLE: begin
               if (!busy_q) begin
                  if (dvalid_i) begin
                     word_q  <= data_i;
                     cnt_q   <= '0;
                     pkt_q   <= '0;
                     state_q <= ENCODE;
                  end else if (flush_i) begin
                     cnt_q   <= '0;
                     pkt_q   <= '0;
                     state_q <= FLUSH;
                  end
               end
            end
            ENCODE: begin
               pkt_q  <= {pkt_q[PW-3:0], p0, p1};
               word_q <= word_q >> 1;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CW'(DATA_W - 1)) begin
                  last_q  <= 1'b0;
                  state_q <= OUT;
               end
            end
            FLUSH: begin
               pkt_q <= {pkt_q[PW-3:0], p0, p1};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(K - 2)) begin
                  last_q  <= 1'b1;
                  state_q <= OUT;
               end
            end
            OUT: begin
               if (!valid_q) begin
                  data_q  <= (last_q ? (pkt_q << TAIL_SH) : pkt_q) ^ err_w;
                  valid_q <= 1'b1;
               end else if (ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign busy_o  = busy_q;

endmodule
